// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
//   INSTR    - 4-bit opcode encoding; codes 0..8 are the original combinational
//              ALU ops, 9..11 add shifts and multiply, 12..15 are illegal.
//   state_t  - control FSM states of alu_seq.
//   is_legal - 1 for any defined opcode.
package alu_pkg;

  typedef enum bit [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    AND  = 4'b0010,
    OR   = 4'b0011,
    NAND = 4'b0100,
    NOR  = 4'b0101,
    NOT  = 4'b0110,
    XOR  = 4'b0111,
    XNOR = 4'b1000,
    SHL  = 4'b1001,
    SHR  = 4'b1010,
    MUL  = 4'b1011
  } INSTR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Defined opcodes are contiguous from 0 up to MUL.
  function automatic logic is_legal(input logic [3:0] sel);
    return (sel <= 4'(MUL));
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the decoder side and alu_seq.
//   Request : in_valid, in_ready, A, B, sel, c_in
//   Response: out_valid, out_ready, Y, C, V, Z, N, E
// master = requester/consumer (drives request and out_ready),
// slave  = the ALU (drives in_ready and the result).
interface alu_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       sel;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             C;
  logic             V;
  logic             Z;
  logic             N;
  logic             E;

  modport master (
    output in_valid, A, B, sel, c_in, out_ready,
    input  in_ready, out_valid, Y, C, V, Z, N, E
  );

  modport slave (
    input  in_valid, A, B, sel, c_in, out_ready,
    output in_ready, out_valid, Y, C, V, Z, N, E
  );

endinterface

// File: rtl/alu_comb.sv
// alu_comb: combinational datapath for every single-cycle opcode.
//   a, b  - operands; shifts use b[CNT_W-1:0] as the shift amount
//   sel   - opcode (alu_pkg::INSTR)
//   c_in  - carry in, ADD only
//   y     - result (zero for MUL, which is handled by the sequencer, and for
//           illegal opcodes)
//   c, v  - carry/borrow/shifted-out bit and signed overflow
//   e     - illegal opcode
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             c_in,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             e
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [CNT_W-1:0] sh;

  assign sh = b[CNT_W-1:0];

  assign add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // One guard bit beyond the operand catches the last bit shifted out.
  // For sh == 0 the guard stays 0, for sh == WIDTH it holds the far-end
  // operand bit, and for sh > WIDTH everything has left the vector.
  assign shl_ext = {1'b0, a} << sh;
  assign shr_ext = {a, 1'b0} >> sh;

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    e = ~is_legal(sel);
    case (sel)
      ADD: begin
        y = add_ext[WIDTH-1:0];
        c = add_ext[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        y = sub_ext[WIDTH-1:0];
        c = sub_ext[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      AND:  y = a & b;
      OR:   y = a | b;
      NAND: y = ~(a & b);
      NOR:  y = ~(a | b);
      NOT:  y = ~a;
      XOR:  y = a ^ b;
      XNOR: y = ~(a ^ b);
      SHL: begin
        y = shl_ext[WIDTH-1:0];
        c = shl_ext[WIDTH];
      end
      SHR: begin
        y = shr_ext[WIDTH:1];
        c = shr_ext[0];
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and a shift-add multiply.
//   clk - clock, all state changes on the rising edge
//   rst - synchronous active-high reset
//   bus - alu_seq_if slave: request (in_valid/in_ready, A, B, sel, c_in) and
//         registered response (out_valid/out_ready, Y, C, V, Z, N, E)
// Single-cycle ops deliver out_valid one cycle after the accept. MUL spends
// WIDTH cycles in BUSY, one partial product per cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic [WIDTH-1:0]     y_reg;
  logic                 c_reg;
  logic                 v_reg;
  logic                 z_reg;
  logic                 n_reg;
  logic                 e_reg;
  logic                 out_valid_reg;

  logic [WIDTH-1:0]     comb_y;
  logic                 comb_c;
  logic                 comb_v;
  logic                 comb_e;

  logic                 in_ready;
  logic                 accept;
  logic                 is_mul;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a    (bus.A),
    .b    (bus.B),
    .sel  (bus.sel),
    .c_in (bus.c_in),
    .y    (comb_y),
    .c    (comb_c),
    .v    (comb_v),
    .e    (comb_e)
  );

  // A result waiting in DONE can be replaced in the same cycle it is taken,
  // which gives back-to-back throughput. Held low while rst is asserted.
  assign in_ready = ~rst && ((state_reg == IDLE) ||
                             ((state_reg == DONE) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = (bus.sel == 4'(MUL));

  // The multiplicand walks left while the multiplier walks right, so the LSB
  // of mplier_reg always selects the correctly weighted partial product.
  assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      c_reg         <= 1'b0;
      v_reg         <= 1'b0;
      z_reg         <= 1'b0;
      n_reg         <= 1'b0;
      e_reg         <= 1'b0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // Result consumed; a simultaneous accept below overrides this.
          if ((state_reg == DONE) && bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
          if (accept) begin
            if (is_mul) begin
              mcand_reg     <= {{WIDTH{1'b0}}, bus.A};
              mplier_reg    <= bus.B;
              acc_reg       <= '0;
              cnt_reg       <= CNT_W'(WIDTH);
              out_valid_reg <= 1'b0;
              state_reg     <= BUSY;
            end else begin
              y_reg         <= comb_y;
              c_reg         <= comb_c;
              v_reg         <= comb_v;
              z_reg         <= (comb_y == '0);
              n_reg         <= comb_y[WIDTH-1];
              e_reg         <= comb_e;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        BUSY: begin
          acc_reg    <= acc_next;
          mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg - CNT_W'(1);
          // Last iteration: the product is complete in acc_next.
          if (cnt_reg == CNT_W'(1)) begin
            y_reg         <= acc_next[WIDTH-1:0];
            c_reg         <= |acc_next[2*WIDTH-1:WIDTH];
            v_reg         <= 1'b0;
            z_reg         <= (acc_next[WIDTH-1:0] == '0);
            n_reg         <= acc_next[WIDTH-1];
            e_reg         <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.Y         = y_reg;
  assign bus.C         = c_reg;
  assign bus.V         = v_reg;
  assign bus.Z         = z_reg;
  assign bus.N         = n_reg;
  assign bus.E         = e_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, randomized ops against an arithmetic
// reference model, and hand sequences for backpressure and reset mid-MUL.
module tb_alu_seq;

  localparam int W   = 8;
  localparam int SHW = 4;   // shift-amount field width for W = 8

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
    logic         e;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic         cin;
    res_t         exp;
    int           lat;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t got, input res_t exp);
    check($sformatf("%s.Y", tag), 64'(got.y), 64'(exp.y));
    check($sformatf("%s.C", tag), 64'(got.c), 64'(exp.c));
    check($sformatf("%s.V", tag), 64'(got.v), 64'(exp.v));
    check($sformatf("%s.Z", tag), 64'(got.z), 64'(exp.z));
    check($sformatf("%s.N", tag), 64'(got.n), 64'(exp.n));
    check($sformatf("%s.E", tag), 64'(got.e), 64'(exp.e));
  endtask

  function automatic logic bit1(input int x);
    return (x != 0);
  endfunction

  // Reference model from the arithmetic definitions of each operation.
  function automatic res_t model(input int a, input int b, input int s, input int cin);
    res_t r;
    int   m, half, sa, sb, t, sh, ss;
    m    = (1 << W) - 1;
    half = 1 << (W - 1);
    sa   = (a >= half) ? a - (1 << W) : a;
    sb   = (b >= half) ? b - (1 << W) : b;
    sh   = b % (1 << SHW);
    r    = '0;
    t    = 0;
    case (s)
      0: begin
        t   = a + b + cin;
        ss  = sa + sb + cin;
        r.c = bit1(int'(t > m));
        r.v = bit1(int'(ss > half - 1 || ss < -half));
      end
      1: begin
        t   = a - b;
        ss  = sa - sb;
        r.c = bit1(int'(a >= b));
        r.v = bit1(int'(ss > half - 1 || ss < -half));
      end
      2: t = a & b;
      3: t = a | b;
      4: t = ~(a & b);
      5: t = ~(a | b);
      6: t = ~a;
      7: t = a ^ b;
      8: t = ~(a ^ b);
      9: begin
        if (sh == 0) t = a;
        else if (sh <= W) begin
          t   = a << sh;
          r.c = bit1((a >> (W - sh)) & 1);
        end else t = 0;
      end
      10: begin
        if (sh == 0) t = a;
        else if (sh <= W) begin
          t   = a >> sh;
          r.c = bit1((a >> (sh - 1)) & 1);
        end else t = 0;
      end
      11: begin
        t   = a * b;
        r.c = bit1(int'(t > m));
      end
      default: r.e = 1'b1;
    endcase
    r.y = W'(t & m);
    r.z = (r.y == '0);
    r.n = r.y[W-1];
    return r;
  endfunction

  // Issue one op, wait for its result, consume it. Called just after a
  // falling edge; returns just after a falling edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                       input logic cin, output res_t got, output int lat, output int leak);
    int n;
    got  = '0;
    lat  = 0;
    leak = 0;
    bus.A         = a;
    bus.B         = b;
    bus.sel       = s;
    bus.c_in      = cin;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (bus.in_ready) leak++;
    end
    check("result_valid", 64'(bus.out_valid), 64'd1);
    got = {bus.Y, bus.C, bus.V, bus.Z, bus.N, bus.E};
    $display("op sel=%0d A=%02h B=%02h cin=%0d -> Y=%02h C=%0d V=%0d Z=%0d N=%0d E=%0d lat=%0d",
             s, a, b, cin, got.y, got.c, got.v, got.z, got.n, got.e, lat);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t got, exp, snap;
    int   lat, leak, stale;
    logic [W-1:0] ra, rb;
    logic [3:0]   rs;
    logic         rc;

    //            a      b      sel    cin     {y, c, v, z, n, e}                              lat
    vecs[0]  = '{8'hFF, 8'h01, 4'd0,  1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 1};
    vecs[1]  = '{8'h7F, 8'h01, 4'd0,  1'b0, '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 1};
    vecs[2]  = '{8'h05, 8'h07, 4'd1,  1'b1, '{8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 1};
    vecs[3]  = '{8'h0D, 8'h0B, 4'd11, 1'b0, '{8'h8F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 9};
    vecs[4]  = '{8'h10, 8'h10, 4'd11, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 9};
    vecs[5]  = '{8'h81, 8'h01, 4'd9,  1'b0, '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, 1};
    vecs[6]  = '{8'h81, 8'h08, 4'd10, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 1};
    vecs[7]  = '{8'h3C, 8'h5A, 4'd15, 1'b1, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}, 1};
    vecs[8]  = '{8'h10, 8'h20, 4'd0,  1'b1, '{8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1};
    vecs[9]  = '{8'h80, 8'h01, 4'd1,  1'b0, '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 1};
    vecs[10] = '{8'h0F, 8'hAA, 4'd6,  1'b0, '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 1};
    vecs[11] = '{8'h81, 8'h09, 4'd9,  1'b0, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 1};
    vecs[12] = '{8'h81, 8'h00, 4'd10, 1'b0, '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 1};
    vecs[13] = '{8'hAA, 8'h55, 4'd8,  1'b0, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.sel       = 4'd0;
    bus.c_in      = 1'b0;
    rst           = 1'b1;

    // Reset state.
    @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_res("post_reset", {bus.Y, bus.C, bus.V, bus.Z, bus.N, bus.E}, '0);
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].cin, got, lat, leak);
      check_res($sformatf("vec%0d", i), got, vecs[i].exp);
      check($sformatf("vec%0d.lat", i), 64'(lat), 64'(vecs[i].lat));
      if (vecs[i].sel == 4'd11) check($sformatf("vec%0d.busy_ready", i), 64'(leak), 64'd0);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      exp = model(int'(ra), int'(rb), int'(rs), int'(rc));
      do_op(ra, rb, rs, rc, got, lat, leak);
      check_res($sformatf("rnd%0d", i), got, exp);
      check($sformatf("rnd%0d.lat", i), 64'(lat), 64'((rs == 4'd11) ? 9 : 1));
    end

    // Backpressure on an XOR result, then a back-to-back ADD.
    ra = W'($urandom_range(0, 255));
    rb = W'($urandom_range(0, 255));
    exp = model(int'(ra), int'(rb), 7, 0);
    bus.A = ra; bus.B = rb; bus.sel = 4'd7; bus.c_in = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    snap = {bus.Y, bus.C, bus.V, bus.Z, bus.N, bus.E};
    check_res("bp_first", snap, exp);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_res($sformatf("bp_hold%0d", k), {bus.Y, bus.C, bus.V, bus.Z, bus.N, bus.E}, snap);
      check($sformatf("bp_hold%0d.out_valid", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold%0d.in_ready", k), 64'(bus.in_ready), 64'd0);
    end
    $display("xor A=%02h B=%02h held 5 cycles Y=%02h", ra, rb, snap.y);
    bus.A = 8'h03; bus.B = 8'h04; bus.sel = 4'd0; bus.c_in = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; bus.out_ready = 1'b0; end
    @(negedge clk);
    check("b2b_valid", 64'(bus.out_valid), 64'd1);
    check_res("b2b", {bus.Y, bus.C, bus.V, bus.Z, bus.N, bus.E}, '{8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    $display("b2b add 03+04 Y=%02h", bus.Y);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);

    // Leave nonzero Y/flags, then reset in the 4th BUSY cycle of a MUL.
    do_op(8'h05, 8'h07, 4'd1, 1'b0, got, lat, leak);
    check("pre_rst_N", 64'(got.n), 64'd1);
    bus.A = 8'h0D; bus.B = 8'h0B; bus.sel = 4'd11; bus.c_in = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    check("mulrst_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mulrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_res("mulrst", {bus.Y, bus.C, bus.V, bus.Z, bus.N, bus.E}, '0);
    check("mulrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("mulrst_in_ready_next", 64'(bus.in_ready), 64'd1);
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("mulrst_no_stale", 64'(stale), 64'd0);
    $display("reset mid-mul: Y=%02h out_valid=%0d", bus.Y, bus.out_valid);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
